// File: rtl/muldiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_pkg : op encodings, FSM states and operand-signedness helpers. Rev 1.0
// ---------------------------------------------------------------------------
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_sign_ctl : operand magnitude/sign extraction and final result
// sign-correction/select (combinational). Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_sign_ctl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [XLEN-1:0]   abs_a_o,
  output logic [XLEN-1:0]   abs_b_o,
  output logic              neg_res_o,
  output logic              b_zero_o,
  input  logic [2:0]        fop_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic              fneg_i,
  input  logic              fbzero_i,
  input  logic [XLEN-1:0]   fa_i,
  output logic [XLEN-1:0]   res_o
);

  logic              sa, sb;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   hi, lo;

  always_comb begin
    sa        = a_signed(op_i) & a_i[XLEN-1];
    sb        = b_signed(op_i) & b_i[XLEN-1];
    abs_a_o   = sa ? -a_i : a_i;
    abs_b_o   = sb ? -b_i : b_i;
    // Remainder takes the dividend's sign; quotient and product the XOR.
    neg_res_o = is_rem(op_i) ? sa : (sa ^ sb);
    b_zero_o  = (b_i == '0);
  end

  always_comb begin
    prod = fneg_i ? -acc_i : acc_i;
    hi   = acc_i[2*XLEN-1:XLEN];
    lo   = acc_i[XLEN-1:0];
    if (!is_div(fop_i)) begin
      res_o = (fop_i == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (is_rem(fop_i)) begin
      res_o = fbzero_i ? fa_i : (fneg_i ? -hi : hi);
    end else begin
      res_o = fbzero_i ? '1 : (fneg_i ? -lo : lo);
    end
  end

endmodule
`default_nettype wire

// File: rtl/iterative_muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iterative_muldiv_unit : multi-cycle shift-add multiplier / restoring divider
// for the RV32M-style op set, one iteration per cycle. Rev 1.0
// ---------------------------------------------------------------------------
module iterative_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, a_q, result_q;
  logic              neg_q, bzero_q;

  logic [XLEN-1:0]   abs_a, abs_b, fix_res, div_diff;
  logic [XLEN:0]     mul_sum, div_shift;
  logic              neg_res, b_zero, div_ge, accept;

  muldiv_sign_ctl #(.XLEN(XLEN)) u_sign_ctl (
    .op_i      (op),
    .a_i       (a),
    .b_i       (b),
    .abs_a_o   (abs_a),
    .abs_b_o   (abs_b),
    .neg_res_o (neg_res),
    .b_zero_o  (b_zero),
    .fop_i     (op_q),
    .acc_i     (acc_q),
    .fneg_i    (neg_q),
    .fbzero_i  (bzero_q),
    .fa_i      (a_q),
    .res_o     (fix_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && !flush) begin
          state_d = S_CALC;
          accept  = 1'b1;
        end
      end
      S_CALC: begin
        if (flush)                              state_d = S_IDLE;
        else if (cnt_q == CNT_W'(XLEN - 1))     state_d = S_FIX;
      end
      S_FIX:   state_d = flush ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // acc holds {partial product hi, multiplier} or {partial remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    if (is_div(op_q))
      acc_d = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    else
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op;
        acc_q   <= {{XLEN{1'b0}}, (is_div(op) ? abs_a : abs_b)};
        opnd_q  <= is_div(op) ? abs_b : abs_a;
        a_q     <= a;
        neg_q   <= neg_res;
        bzero_q <= b_zero;
        cnt_q   <= '0;
      end else if (state_q == S_CALC) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == S_FIX && !flush) result_q <= fix_res;
    end
  end

  assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_iterative_muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iterative_muldiv_unit : directed self-checking bench, XLEN=32. Rev 1.0
// ---------------------------------------------------------------------------
module tb_iterative_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN    = 32;
  localparam int LAT     = XLEN + 2;  // negedges from accept edge to done
  localparam int BUSY_N  = XLEN + 1;

  logic            clk = 1'b0;
  logic            reset, start, flush;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  logic            ready, busy, done;
  logic [XLEN-1:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iterative_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges until done (bounded); a timeout shows up as a wrong count.
  task automatic wait_done(output int cyc, output int bcnt);
    bit got;
    cyc = 0; bcnt = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
      else if (busy) bcnt++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [XLEN-1:0] x,
                       input logic [XLEN-1:0] y, input logic [XLEN-1:0] exp);
    int cyc, bcnt;
    launch(o, x, y);
    wait_done(cyc, bcnt);
    chk({tag, "_lat"}, cyc, LAT);
    chk({tag, "_busy"}, bcnt, BUSY_N);
    chk({tag, "_res"}, result, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 1'b0);
    chk({tag, "_ready"}, ready, 1'b1);
  endtask

  initial begin
    int cyc, bcnt, seen;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", ready, 1'b1);

    // Main function, hand-computed vectors
    do_op("mul",      OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mulh",     OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    do_op("mulhu",    OP_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    do_op("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
    do_op("mulhu_ff", OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("divu",     OP_DIVU,   32'd100,        32'd7,         32'd14);
    do_op("remu",     OP_REMU,   32'd100,        32'd7,         32'd2);
    do_op("div_neg",  OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    do_op("rem_neg",  OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    do_op("div_ovf",  OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem_ovf",  OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);
    do_op("div_z",    OP_DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF);
    do_op("rem_z",    OP_REM,    32'd5,          32'd0,         32'd5);
    do_op("rem_zneg", OP_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB);
    do_op("divu_z",   OP_DIVU,   32'd9,          32'd0,         32'hFFFF_FFFF);

    // Start while busy must be ignored (operand inputs also change)
    launch(OP_MUL, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    op = OP_DIVU; a = 32'd9; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcnt);
    chk("ign_lat", 6 + cyc, LAT);
    chk("ign_res", result, 32'd42);
    @(negedge clk);
    chk("ign_idle", busy, 1'b0);

    // Back-to-back: start asserted during the DONE cycle
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(cyc, bcnt);
    chk("b2b_first", result, 32'd14);
    op = OP_REMU; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bcnt);
    chk("b2b_lat", cyc, LAT);
    chk("b2b_res", result, 32'd2);
    @(negedge clk);

    // Flush at CALC cycle 10: no done, result retained
    launch(OP_MUL, 32'd3, 32'd3);
    repeat (10) @(negedge clk);
    chk("fl_busy_before", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("fl_busy", busy, 1'b0);
    chk("fl_ready", ready, 1'b1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("fl_nodone", seen, 0);
    chk("fl_result", result, 32'd2);

    // Flush and start together in IDLE: start is dropped
    @(negedge clk);
    op = OP_MUL; a = 32'd5; b = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("flst_busy", busy, 1'b0);
    chk("flst_ready", ready, 1'b1);

    // Async reset mid-op
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready", ready, 1'b1);
    chk("arst_done", done, 1'b0);
    chk("arst_result", result, '0);
    @(negedge clk);
    reset = 1'b0;
    do_op("post_rst", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
